// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg -- shared definitions for the RV32 front end.
//   XLEN / ILEN       : address and instruction widths
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   fetch_state_e     : fetch engine states (IDLE / REQ / WAIT)
// ----------------------------------------------------------------------------
package rv32_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,  // no request on the bus
        FETCH_REQ  = 2'd1,  // request asserted, waiting for grant
        FETCH_WAIT = 2'd2   // granted, waiting for read data
    } fetch_state_e;
endpackage

// File: rtl/rv32_fetch_buf.sv
// ----------------------------------------------------------------------------
// rv32_fetch_buf -- one-entry prefetch buffer (instruction word + its pc).
//   clk, rst_n : clock, synchronous active-low reset
//   flush_i    : drop the entry (highest priority)
//   load_i     : capture data_i/pc_i (wins over pop_i in the same cycle)
//   pop_i      : entry handed to the instruction register
//   valid_o, data_o, pc_o : current entry
// ----------------------------------------------------------------------------
module rv32_fetch_buf
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            pop_i,
    input  logic [ILEN-1:0] data_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [ILEN-1:0] data_o,
    output logic [XLEN-1:0] pc_o
);
    logic            valid_q;
    logic [ILEN-1:0] data_q;
    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            pc_q    <= pc_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign pc_o    = pc_q;
endmodule

// File: rtl/rv32_fetch_unit.sv
// ----------------------------------------------------------------------------
// rv32_fetch_unit -- sequential instruction fetch with one-entry prefetch
// and branch/jump redirect.
//   clk, rst_n        : clock, synchronous active-low reset
//   i_ready           : downstream takes the presented instruction
//   i_pcsel/i_alu_target : redirect request and target (only on consume)
//   o_imem_req/o_imem_addr, i_imem_gnt, i_imem_rvalid/i_imem_rdata :
//                       single-outstanding instruction memory port
//   o_valid/o_instruction/o_pc/o_pc_plus4 : instruction register contents
//   o_misaligned      : one-cycle pulse after a redirect to a non-word target
// ----------------------------------------------------------------------------
module rv32_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ready,
    input  logic            i_pcsel,
    input  logic [XLEN-1:0] i_alu_target,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [ILEN-1:0] i_imem_rdata,
    output logic            o_valid,
    output logic [ILEN-1:0] o_instruction,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_misaligned
);
    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fa_q, fa_d;        // next address to fetch
    logic [XLEN-1:0] addr_q, addr_d;    // address of the in-flight transaction
    logic            kill_q, kill_d;
    logic            ir_valid_q, ir_valid_d;
    logic [ILEN-1:0] ir_data_q, ir_data_d;
    logic [XLEN-1:0] ir_pc_q, ir_pc_d;
    logic [XLEN-1:0] ir_pc4_q;
    logic            mis_q, mis_d;

    logic            pb_valid, pb_load, pb_pop, pb_occ_d;
    logic [ILEN-1:0] pb_data;
    logic [XLEN-1:0] pb_pc;

    logic            consume, redirect, live_rv, room;

    assign consume  = ir_valid_q & i_ready;
    assign redirect = consume & i_pcsel;
    // Read data only counts in WAIT and only for a transaction not orphaned by a redirect.
    assign live_rv  = i_imem_rvalid & (state_q == FETCH_WAIT) & ~kill_q;

    rv32_fetch_buf u_pb (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .load_i  (pb_load),
        .pop_i   (pb_pop),
        .data_i  (i_imem_rdata),
        .pc_i    (addr_q),
        .valid_o (pb_valid),
        .data_o  (pb_data),
        .pc_o    (pb_pc)
    );

    // Instruction register / prefetch buffer steering
    always_comb begin
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        pb_load    = 1'b0;
        pb_pop     = 1'b0;
        if (redirect) begin
            ir_valid_d = 1'b0;
        end else if (consume || !ir_valid_q) begin
            if (pb_valid) begin
                ir_valid_d = 1'b1;
                ir_data_d  = pb_data;
                ir_pc_d    = pb_pc;
                pb_pop     = 1'b1;
                pb_load    = live_rv;
            end else if (live_rv) begin
                ir_valid_d = 1'b1;
                ir_data_d  = i_imem_rdata;
                ir_pc_d    = addr_q;
            end else begin
                ir_valid_d = 1'b0;
            end
        end else if (live_rv) begin
            pb_load = 1'b1;
        end
        pb_occ_d = pb_load | (pb_valid & ~pb_pop & ~redirect);
        // A new request is only launched when nothing is outstanding, so the
        // budget check reduces to "at least one of IR/PB will be free".
        room  = ~(ir_valid_d & pb_occ_d);
        mis_d = redirect & (i_alu_target[1:0] != 2'b00);
    end

    // Fetch engine
    always_comb begin
        state_d = state_q;
        fa_d    = fa_q;
        kill_d  = kill_q;
        addr_d  = addr_q;
        case (state_q)
            FETCH_IDLE: if (room) state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (i_imem_gnt) begin
                    state_d = FETCH_WAIT;
                    // A killed request still handshakes but must not move FA off the target.
                    if (!kill_q) fa_d = fa_q + 32'd4;
                end
            end
            FETCH_WAIT: begin
                if (i_imem_rvalid) begin
                    state_d = room ? FETCH_REQ : FETCH_IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        if (redirect) begin
            fa_d = {i_alu_target[XLEN-1:2], 2'b00};
            if (state_q == FETCH_REQ || (state_q == FETCH_WAIT && !i_imem_rvalid))
                kill_d = 1'b1;
        end
        // Request address is latched once on entry and held until the grant.
        if (state_d == FETCH_REQ && state_q != FETCH_REQ) addr_d = fa_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            fa_q       <= RESET_PC;
            addr_q     <= '0;
            kill_q     <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            ir_pc4_q   <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            addr_q     <= addr_d;
            kill_q     <= kill_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            ir_pc4_q   <= ir_pc_d + 32'd4;
            mis_q      <= mis_d;
        end
    end

    assign o_imem_req    = (state_q == FETCH_REQ);
    assign o_imem_addr   = addr_q;
    assign o_valid       = ir_valid_q;
    assign o_instruction = ir_data_q;
    assign o_pc          = ir_pc_q;
    assign o_pc_plus4    = ir_pc4_q;
    assign o_misaligned  = mis_q;
endmodule

// File: tb/tb_rv32_fetch_unit.sv
module tb_rv32_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, i_ready = 1'b0, i_pcsel = 1'b0;
    logic [31:0] i_alu_target = '0;
    logic        i_imem_gnt = 1'b0, i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_imem_req, o_valid, o_misaligned;
    logic [31:0] o_imem_addr, o_instruction, o_pc, o_pc_plus4;

    // second instance: wrap-around reset vector, always-stalled consumer
    logic        g2 = 1'b0, rv2 = 1'b0;
    logic [31:0] a2 = '0, rd2 = '0;
    logic        o2_req, o2_valid, o2_mis;
    logic [31:0] o2_addr, o2_instr, o2_pc, o2_pc4;
    logic [31:0] q2[$];

    int total = 0, bad = 0, cyc_n = 0;

    // memory model for the main instance
    int          rv_lat = 1, mb_cnt = 0, last_rv_cyc = -100;
    logic        mb_busy = 1'b0, inj_rv = 1'b0;
    logic [31:0] mb_addr = '0;
    logic [31:0] gq[$];
    int          gcq[$];

    // program-order model
    logic [31:0] exp_pc = '0;
    logic        exp_mis = 1'b0, pv = 1'b0, preq = 1'b0;
    logic [31:0] paddr = '0;

    rv32_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .i_ready(i_ready), .i_pcsel(i_pcsel),
        .i_alu_target(i_alu_target), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_valid(o_valid), .o_instruction(o_instruction), .o_pc(o_pc),
        .o_pc_plus4(o_pc_plus4), .o_misaligned(o_misaligned)
    );

    rv32_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_ready(1'b0), .i_pcsel(1'b0),
        .i_alu_target(32'h0), .o_imem_req(o2_req), .o_imem_addr(o2_addr),
        .i_imem_gnt(g2), .i_imem_rvalid(rv2), .i_imem_rdata(rd2),
        .o_valid(o2_valid), .o_instruction(o2_instr), .o_pc(o2_pc),
        .o_pc_plus4(o2_pc4), .o_misaligned(o2_mis)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a << 8) | 32'h33;
    endfunction

    always @(negedge clk) begin
        #1;
        rv2 = g2;
        rd2 = memf(a2);
        g2  = o2_req;
        a2  = o2_addr;
        if (g2) q2.push_back(a2);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    // Inputs seen here are those the DUT sampled on the edge just passed.
    task automatic model_chk();
        if (!rst_n) begin
            exp_pc  = 32'h0;
            exp_mis = 1'b0;
            chk("rst_flags", {29'b0, o_valid, o_imem_req, o_misaligned}, 32'h0);
            chk("rst_data", o_instruction | o_pc | o_pc_plus4 | o_imem_addr, 32'h0);
        end else begin
            exp_mis = 1'b0;
            if (pv && i_ready) begin
                if (i_pcsel) begin
                    exp_pc  = i_alu_target & 32'hFFFF_FFFC;
                    exp_mis = (i_alu_target[1:0] != 2'b00);
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            chk("m_misaligned", 32'(o_misaligned), 32'(exp_mis));
            if (o_valid) begin
                chk("m_pc", o_pc, exp_pc);
                chk("m_instr", o_instruction, memf(exp_pc));
                chk("m_pc4", o_pc_plus4, exp_pc + 32'd4);
            end
            if (preq && !i_imem_gnt) begin
                chk("m_req_hold", 32'(o_imem_req), 32'd1);
                chk("m_addr_hold", o_imem_addr, paddr);
            end
        end
        pv    = o_valid;
        preq  = o_imem_req;
        paddr = o_imem_addr;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_chk();
        #1;
        cyc_n++;
        i_imem_rvalid = 1'b0;
        if (mb_busy) begin
            if (mb_cnt == 0) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = memf(mb_addr);
                mb_busy       = 1'b0;
                last_rv_cyc   = cyc_n;
            end else mb_cnt--;
        end
        if (inj_rv) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = 32'hDEAD_0000;
            inj_rv        = 1'b0;
        end
        i_imem_gnt = 1'b0;
        if (o_imem_req && !mb_busy) begin
            i_imem_gnt = 1'b1;
            mb_busy    = 1'b1;
            mb_addr    = o_imem_addr;
            mb_cnt     = rv_lat - 1;
            gq.push_back(o_imem_addr);
            gcq.push_back(cyc_n);
        end
    endtask

    initial begin
        int r0;
        bit done;
        repeat (3) cyc();
        chk("rst_req", 32'(o_imem_req), 32'd0);

        // first fetch: request at cycle 1, instruction at cycle 3
        rst_n = 1'b1;
        cyc();
        chk("c1_req", 32'(o_imem_req), 32'd1);
        chk("c1_addr", o_imem_addr, 32'h0);
        cyc();
        chk("c2_valid", 32'(o_valid), 32'd0);
        cyc();
        chk("c3_valid", 32'(o_valid), 32'd1);
        chk("c3_pc", o_pc, 32'h0);
        chk("c3_pc4", o_pc_plus4, 32'h4);
        chk("c3_instr", o_instruction, 32'h0000_0033);

        // stalled consumer; pcsel must be ignored without consume
        i_pcsel = 1'b1; i_alu_target = 32'h0000_0555;
        repeat (8) cyc();
        i_pcsel = 1'b0;
        chk("stall_nfetch", 32'(gq.size()), 32'd2);
        if (gq.size() >= 2) begin
            chk("stall_f0", gq[0], 32'h0);
            chk("stall_f1", gq[1], 32'h4);
        end
        chk("stall_req", 32'(o_imem_req), 32'd0);
        chk("stall_pc", o_pc, 32'h0);
        chk("stall_mis", 32'(o_misaligned), 32'd0);
        i_ready = 1'b1;
        cyc();
        chk("drain_valid", 32'(o_valid), 32'd1);
        chk("drain_pc", o_pc, 32'h4);

        // redirect at pc 8 while fetch of 12 waits for data
        rv_lat = 3;
        done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            cyc();
            if (o_valid && o_pc == 32'h8) begin
                if (mb_busy && mb_addr == 32'hC && !i_imem_gnt) begin
                    i_ready = 1'b1; i_pcsel = 1'b1; i_alu_target = 32'h0000_0100; done = 1'b1;
                end else i_ready = 1'b0;
            end else i_ready = 1'b1;
        end
        chk("reach_pc8_wait", 32'(done), 32'd1);
        gq.delete(); gcq.delete();
        cyc();
        i_pcsel = 1'b0;
        for (int n = 0; n < 20 && gq.size() == 0; n++) cyc();
        chk("redir_req_seen", 32'(gq.size() > 0), 32'd1);
        if (gq.size() > 0) begin
            chk("redir_addr", gq[0], 32'h100);
            chk("redir_lat", 32'(gcq[0]), 32'(last_rv_cyc + 1));
        end
        for (int n = 0; n < 20 && !o_valid; n++) cyc();
        chk("redir_pc", o_pc, 32'h100);
        chk("redir_instr", o_instruction, 32'h0001_0033);

        // misaligned redirect from an idle engine
        rv_lat = 1; i_ready = 1'b0;
        repeat (8) cyc();
        chk("pre_mis_valid", 32'(o_valid), 32'd1);
        chk("pre_mis_idle", 32'(o_imem_req), 32'd0);
        i_ready = 1'b1; i_pcsel = 1'b1; i_alu_target = 32'h0000_0203;
        cyc();
        i_pcsel = 1'b0; i_ready = 1'b0;
        chk("mis_pulse", 32'(o_misaligned), 32'd1);
        chk("mis_req", 32'(o_imem_req), 32'd1);
        chk("mis_addr", o_imem_addr, 32'h200);
        cyc();
        chk("mis_clear", 32'(o_misaligned), 32'd0);
        for (int n = 0; n < 20 && !o_valid; n++) cyc();
        chk("mis_pc", o_pc, 32'h200);

        // wrap-around reset vector instance
        chk("wrap_nfetch", 32'(q2.size()), 32'd2);
        if (q2.size() >= 2) begin
            chk("wrap_f0", q2[0], 32'hFFFF_FFFC);
            chk("wrap_f1", q2[1], 32'h0);
        end
        chk("wrap_pc", o2_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", o2_pc4, 32'h0);
        chk("wrap_instr", o2_instr, 32'hFFFF_FC33);

        // reset while waiting for read data; late rvalids must be ignored
        rv_lat = 3; i_ready = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            cyc();
            if (mb_busy && !i_imem_gnt) done = 1'b1;
        end
        chk("reach_wait", 32'(done), 32'd1);
        rst_n = 1'b0; r0 = cyc_n;
        repeat (3) cyc();
        chk("rv_in_rst", 32'(last_rv_cyc > r0 && last_rv_cyc <= r0 + 3), 32'd1);
        rst_n = 1'b1; inj_rv = 1'b1; i_ready = 1'b0; rv_lat = 1;
        gq.delete();
        cyc();
        chk("post_rst_valid0", 32'(o_valid), 32'd0);
        chk("post_rst_req", 32'(o_imem_req), 32'd1);
        chk("post_rst_addr", o_imem_addr, 32'h0);
        cyc();
        chk("post_rst_valid1", 32'(o_valid), 32'd0);
        cyc();
        chk("post_rst_valid2", 32'(o_valid), 32'd1);
        chk("post_rst_pc", o_pc, 32'h0);
        chk("post_rst_instr", o_instruction, 32'h0000_0033);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/rv32_fetch_unit.md
RV32_FETCH_UNIT -- requirements
Module: rv32_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the address of the first fetch after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 i_ready  input  1  downstream (controller/decode) accepts the current instruction.
REQ-005 i_pcsel  input  1  controller PCSel; 1 = take i_alu_target as next PC.
REQ-006 i_alu_target  input  32  branch/jump target from the ALU.
REQ-007 o_imem_req  output  1  instruction-memory request.
REQ-008 o_imem_addr  output  32  request word address.
REQ-009 i_imem_gnt  input  1  request accepted this cycle.
REQ-010 i_imem_rvalid  input  1  read data valid.
REQ-011 i_imem_rdata  input  32  instruction word.
REQ-012 o_valid  output  1  o_instruction/o_pc hold a valid instruction.
REQ-013 o_instruction  output  32  instruction presented to the controller.
REQ-014 o_pc  output  32  address of o_instruction.
REQ-015 o_pc_plus4  output  32  o_pc + 4, modulo 2^32.
REQ-016 o_misaligned  output  1  one-cycle pulse: redirect target had bits[1:0] != 0.

Function
REQ-017 Engine FSM states SHALL be IDLE (no request), REQ (o_imem_req=1, waiting gnt), WAIT (granted, waiting rvalid).
REQ-018 At most one memory transaction SHALL be outstanding; o_imem_req/o_imem_addr SHALL stay stable from assertion until the gnt cycle.
REQ-019 Two storage slots: IR (drives o_*) and PB (one-entry prefetch buffer); engine SHALL go IDLE->REQ only when (IR occupied + PB occupied + live outstanding) < 2.
REQ-020 Fetch address FA SHALL advance by 4 on every gnt; REQ->WAIT on gnt; WAIT->REQ or IDLE on rvalid per REQ-019.
REQ-021 A live rvalid SHALL load IR if IR is empty or is being consumed that cycle, otherwise PB.
REQ-022 Consume = o_valid & i_ready; on consume with i_pcsel=0, IR SHALL load PB (if valid) or the same-cycle live rvalid, else IR becomes empty.
REQ-023 On consume with i_pcsel=1 (redirect): IR and PB SHALL be emptied, FA SHALL become {i_alu_target[31:2],2'b00}, any transaction in REQ or WAIT SHALL be marked killed.
REQ-024 A killed transaction in REQ SHALL complete its handshake at the old address; its rvalid SHALL be dropped; the target request SHALL issue the cycle after that rvalid.
REQ-025 With no pending transaction, redirect SHALL assert o_imem_req for the target on the next cycle (redirect-to-request latency 1).
REQ-026 o_misaligned SHALL pulse in the cycle after a redirect whose i_alu_target[1:0] != 2'b00.
REQ-027 i_pcsel SHALL be ignored when consume is 0.
REQ-028 FA wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-029 rvalid in IDLE or REQ (protocol violation) SHALL be ignored.
REQ-030 Minimum latency: gnt same cycle as req, rvalid next cycle -> o_valid the cycle after rvalid.

Reset
REQ-031 While rst_n=0: FSM=IDLE, FA=RESET_PC, IR/PB empty, kill flag clear, o_valid=0, o_imem_req=0, o_misaligned=0, o_instruction=0, o_pc=0, o_pc_plus4=0, o_imem_addr=0.
REQ-032 o_imem_req SHALL assert for RESET_PC in the first cycle after rst_n rises.
REQ-033 Reset mid-transaction SHALL discard it; a late rvalid after reset is ignored per REQ-029.

Structure
REQ-034 Shared package rv32_pkg SHALL hold XLEN=32, ILEN=32, RESET_PC default, and the fetch FSM state enum.
REQ-035 PB SHALL be a sub-module rv32_fetch_buf (1-entry data+pc register, valid/flush).

Verification
REQ-036 Reset release, memory gnt immediate, rvalid +1 cycle, data 32'h0000_0033 -> req addr 0 at cycle 1, o_valid=1 at cycle 3, o_pc=0, o_pc_plus4=4.
REQ-037 i_ready=0 for 10 cycles -> exactly two fetches (0, 4), PB holds addr 4, req stays low; i_ready=1 -> o_pc 0 then 4 on consecutive cycles.
REQ-038 Consume at pc=8 with i_pcsel=1, target 32'h0000_0100, speculative fetch of 12 in WAIT -> rvalid for 12 dropped, next req addr 32'h100, o_pc=32'h100 next valid.
REQ-039 Redirect to 32'h0000_0203 -> o_misaligned pulses once, fetch addr 32'h0000_0200.
REQ-040 RESET_PC=32'hFFFF_FFFC -> fetch sequence FFFF_FFFC then 0000_0000.
REQ-041 rst_n low during WAIT, rvalid arrives during reset and one cycle after -> no o_valid, first req at RESET_PC.
